// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared BCD definitions for the N-digit clock counter family.
//   BCD_W       : bits per BCD digit
//   bcd_digit_t : one packed BCD digit
//   to_bcd      : integer -> packed BCD (up to 4 digits), used at elaboration
//   bcd_to_int  : packed BCD (up to 4 digits) -> integer
//   bcd_valid   : digit holds a legal decimal value (0..9)
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  // Digit 0 lands in bits [3:0]; digits at or above ndig are left zero.
  function automatic logic [15:0] to_bcd(input int value, input int ndig);
    logic [15:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < 4; i++) begin
      if (i < ndig) begin
        r[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

  function automatic int bcd_to_int(input logic [15:0] bcd);
    int r;
    int w;
    r = 0;
    w = 1;
    for (int i = 0; i < 4; i++) begin
      r = r + int'(bcd[4*i +: 4]) * w;
      w = w * 10;
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input bcd_digit_t digit);
    return (digit <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One decade of the BCD counter with its own register.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset (digit -> 0)
//   up       : counter is stepping up this cycle
//   down     : counter is stepping down this cycle
//   cin      : lower digits ripple into this one (1 for digit 0)
//   load     : overwrite the digit with load_val (beats up/down)
//   load_val : value to load
//   digit    : current digit value
//   co       : this digit is 9 and is being stepped (ripples an up-carry)
//   bo       : this digit is 0 and is being stepped (ripples a down-borrow)
// -----------------------------------------------------------------------------
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       up,
  input  logic       down,
  input  logic       cin,
  input  logic       load,
  input  bcd_digit_t load_val,
  output bcd_digit_t digit,
  output logic       co,
  output logic       bo
);

  bcd_digit_t digit_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      digit_q <= '0;
    end else if (load) begin
      digit_q <= load_val;
    end else if (up && cin) begin
      digit_q <= (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    end else if (down && cin) begin
      digit_q <= (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
    end
  end

  assign digit = digit_q;
  assign co    = cin & (digit_q == 4'd9);
  assign bo    = cin & (digit_q == 4'd0);

endmodule

// File: rtl/bcd_counter_n.sv
// -----------------------------------------------------------------------------
// bcd_counter_n
// N-digit BCD up/down counter with programmable terminal count, synchronous
// load with validation and chainable carry/borrow (carry_o feeds the next
// stage's inc_i). Optional binary mirror enabled by defining CNT_BINARY_OUT_EN.
//   clk_i       : clock
//   rst_ni      : asynchronous active-low reset
//   inc_i       : count up by one
//   dec_i       : count down by one (inc_i & dec_i together = hold)
//   load_i      : synchronous load request (highest priority)
//   load_bcd_i  : BCD value to load, digit 0 in [3:0]
//   count_bcd_o : registered BCD count
//   carry_o     : combinational wrap MAX_COUNT -> 0 on increment
//   borrow_o    : combinational wrap 0 -> MAX_COUNT on decrement
//   load_err_o  : registered one-cycle pulse after a rejected load
//   count_bin_o : binary mirror of the count (CNT_BINARY_OUT_EN only)
// -----------------------------------------------------------------------------
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int MAX_COUNT  = 59,
  // Derived from MAX_COUNT; not meant to be overridden.
  parameter int BIN_W      = $clog2(MAX_COUNT + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    inc_i,
  input  logic                    dec_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] load_bcd_i,
  output logic [4*NUM_DIGITS-1:0] count_bcd_o,
  output logic                    carry_o,
  output logic                    borrow_o,
  output logic                    load_err_o
`ifdef CNT_BINARY_OUT_EN
  ,
  output logic [BIN_W-1:0]        count_bin_o
`endif
);

  localparam int W = 4 * NUM_DIGITS;

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 4 || MAX_COUNT < 1 ||
        MAX_COUNT >= 10**NUM_DIGITS) begin : g_bad_cfg
      $error("bcd_counter_n: MAX_COUNT=%0d does not fit in NUM_DIGITS=%0d",
             MAX_COUNT, NUM_DIGITS);
    end
  endgenerate

  localparam logic [15:0]  MAX_BCD_FULL = to_bcd(MAX_COUNT, NUM_DIGITS);
  localparam logic [W-1:0] MAX_BCD      = MAX_BCD_FULL[W-1:0];

  logic [W-1:0]          count;
  logic [NUM_DIGITS-1:0] cin;
  logic [NUM_DIGITS-1:0] co;
  logic [NUM_DIGITS-1:0] bo;
  logic [NUM_DIGITS-1:0] digit_ok;

  logic at_max, at_zero;
  logic step_up, step_dn;
  logic load_ok;
  logic dig_load, dig_up, dig_dn;
  logic [W-1:0] dig_load_val;
  logic load_err_q;

  assign at_max  = (count == MAX_BCD);
  assign at_zero = (count == '0);

  // A simultaneous inc/dec cancels; a load masks both.
  assign step_up = inc_i & ~dec_i & ~load_i;
  assign step_dn = dec_i & ~inc_i & ~load_i;

  assign carry_o  = step_up & at_max;
  assign borrow_o = step_dn & at_zero;

  // With every digit legal, an unsigned compare of packed BCD equals a
  // decimal compare, so the range check needs no conversion.
  assign load_ok = (&digit_ok) && (load_bcd_i <= MAX_BCD);

  // Terminal-count wraps reuse the digit load path instead of rippling.
  assign dig_load     = (load_i & load_ok) | carry_o | borrow_o;
  assign dig_load_val = load_i ? load_bcd_i : (carry_o ? '0 : MAX_BCD);
  assign dig_up       = step_up & ~at_max;
  assign dig_dn       = step_dn & ~at_zero;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_digit_t digit_val;

      assign digit_ok[gi] = bcd_valid(load_bcd_i[4*gi +: 4]);

      if (gi == 0) begin : g_first
        assign cin[gi] = 1'b1;
      end else begin : g_rest
        assign cin[gi] = dig_up ? co[gi-1] : bo[gi-1];
      end

      bcd_digit u_digit (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .up       (dig_up),
        .down     (dig_dn),
        .cin      (cin[gi]),
        .load     (dig_load),
        .load_val (dig_load_val[4*gi +: 4]),
        .digit    (digit_val),
        .co       (co[gi]),
        .bo       (bo[gi])
      );

      assign count[4*gi +: 4] = digit_val;
    end
  endgenerate

  // The top digit's ripple outputs have no consumer.
  logic unused_ripple;
  assign unused_ripple = co[NUM_DIGITS-1] ^ bo[NUM_DIGITS-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_i & ~load_ok;
    end
  end

  assign count_bcd_o = count;
  assign load_err_o  = load_err_q;

`ifdef CNT_BINARY_OUT_EN
  logic [BIN_W-1:0] bin_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q <= '0;
    end else if (load_i) begin
      if (load_ok) begin
        bin_q <= BIN_W'(bcd_to_int(16'(load_bcd_i)));
      end
    end else if (carry_o) begin
      bin_q <= '0;
    end else if (borrow_o) begin
      bin_q <= BIN_W'(MAX_COUNT);
    end else if (dig_up) begin
      bin_q <= bin_q + 1'b1;
    end else if (dig_dn) begin
      bin_q <= bin_q - 1'b1;
    end
  end

  assign count_bin_o = bin_q;
`endif

endmodule

// File: tb/tb_bcd_counter_n.sv
module tb_bcd_counter_n;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;

  // seconds stage (main DUT)
  logic       s_inc = 0, s_dec = 0, s_ld = 0;
  logic [7:0] s_lv = '0, s_cnt;
  logic       s_c, s_b, s_e;
  // minutes stage, stepped by seconds carry
  logic       m_ld = 0;
  logic [7:0] m_lv = '0, m_cnt;
  logic       m_c, m_b, m_e;
  // hours stage, stepped by minutes carry
  logic       h_ld = 0;
  logic [7:0] h_lv = '0, h_cnt;
  logic       h_c, h_b, h_e;

`ifdef CNT_BINARY_OUT_EN
  logic [5:0] s_bin, m_bin;
  logic [4:0] h_bin;
`endif

  int n_checks = 0;
  int errors   = 0;

  always #5 clk = ~clk;

  bcd_counter_n #(.NUM_DIGITS(2), .MAX_COUNT(59)) u_sec (
    .clk_i(clk), .rst_ni(rst_ni), .inc_i(s_inc), .dec_i(s_dec),
    .load_i(s_ld), .load_bcd_i(s_lv), .count_bcd_o(s_cnt),
    .carry_o(s_c), .borrow_o(s_b), .load_err_o(s_e)
`ifdef CNT_BINARY_OUT_EN
    , .count_bin_o(s_bin)
`endif
  );

  bcd_counter_n #(.NUM_DIGITS(2), .MAX_COUNT(59)) u_min (
    .clk_i(clk), .rst_ni(rst_ni), .inc_i(s_c), .dec_i(1'b0),
    .load_i(m_ld), .load_bcd_i(m_lv), .count_bcd_o(m_cnt),
    .carry_o(m_c), .borrow_o(m_b), .load_err_o(m_e)
`ifdef CNT_BINARY_OUT_EN
    , .count_bin_o(m_bin)
`endif
  );

  bcd_counter_n #(.NUM_DIGITS(2), .MAX_COUNT(23)) u_hr (
    .clk_i(clk), .rst_ni(rst_ni), .inc_i(m_c), .dec_i(1'b0),
    .load_i(h_ld), .load_bcd_i(h_lv), .count_bcd_o(h_cnt),
    .carry_o(h_c), .borrow_o(h_b), .load_err_o(h_e)
`ifdef CNT_BINARY_OUT_EN
    , .count_bin_o(h_bin)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dec2bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  typedef struct {
    logic       ld;
    logic       inc;
    logic       dec;
    logic [7:0] lv;
    logic [7:0] exp_cnt;  // count after the edge
    logic       exp_c;    // carry before the edge
    logic       exp_b;    // borrow before the edge
    logic       exp_e;    // load_err after the edge
  } vec_t;

  vec_t vecs[20];

`ifdef CNT_BINARY_OUT_EN
  // Binary mirror must track the decimal value of the BCD count every cycle.
  always @(negedge clk) begin
    if (rst_ni) begin
      check("bin_mirror_sec", 32'(s_bin), 32'(s_cnt[7:4] * 10 + s_cnt[3:0]));
      check("bin_mirror_hr", 32'(h_bin), 32'(h_cnt[7:4] * 10 + h_cnt[3:0]));
    end
  end
`endif

  initial begin
    //            ld inc dec lv      cnt   c  b  e
    vecs[0]  = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 0};  // hold at reset value
    vecs[1]  = '{0, 1, 0, 8'h00, 8'h01, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 8'h09, 8'h09, 0, 0, 0};
    vecs[3]  = '{0, 1, 0, 8'h00, 8'h10, 0, 0, 0};  // digit carry 09->10
    vecs[4]  = '{0, 0, 1, 8'h00, 8'h09, 0, 0, 0};  // digit borrow 10->09
    vecs[5]  = '{1, 0, 0, 8'h00, 8'h00, 0, 0, 0};
    vecs[6]  = '{0, 0, 1, 8'h00, 8'h59, 0, 1, 0};  // zero wrap
    vecs[7]  = '{0, 1, 1, 8'h00, 8'h59, 0, 0, 0};  // inc&dec at max
    vecs[8]  = '{0, 1, 0, 8'h00, 8'h00, 1, 0, 0};  // terminal wrap
    vecs[9]  = '{0, 1, 1, 8'h00, 8'h00, 0, 0, 0};  // inc&dec at zero
    vecs[10] = '{1, 0, 0, 8'h45, 8'h45, 0, 0, 0};
    vecs[11] = '{1, 0, 0, 8'h5A, 8'h45, 0, 0, 1};  // bad digit
    vecs[12] = '{0, 0, 0, 8'h00, 8'h45, 0, 0, 0};  // error pulse gone
    vecs[13] = '{1, 0, 0, 8'h60, 8'h45, 0, 0, 1};  // above MAX
    vecs[14] = '{1, 0, 0, 8'hA0, 8'h45, 0, 0, 1};  // bad top digit
    vecs[15] = '{1, 0, 0, 8'h59, 8'h59, 0, 0, 0};  // load exactly MAX
    vecs[16] = '{1, 1, 0, 8'h45, 8'h45, 0, 0, 0};  // load beats inc at 59
    vecs[17] = '{1, 0, 0, 8'h00, 8'h00, 0, 0, 0};
    vecs[18] = '{1, 0, 1, 8'h37, 8'h37, 0, 0, 0};  // load beats dec at 00
    vecs[19] = '{0, 0, 1, 8'h00, 8'h36, 0, 0, 0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", 32'(s_cnt), 32'h00);
    check("reset_err", 32'(s_e), 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;

    // table vectors: drive on negedge, check comb outputs, then registered
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s_ld = vecs[i].ld; s_inc = vecs[i].inc; s_dec = vecs[i].dec; s_lv = vecs[i].lv;
      #1;
      check($sformatf("vec%0d_carry", i), 32'(s_c), 32'(vecs[i].exp_c));
      check($sformatf("vec%0d_borrow", i), 32'(s_b), 32'(vecs[i].exp_b));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_count", i), 32'(s_cnt), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_err", i), 32'(s_e), 32'(vecs[i].exp_e));
    end

    // full up sweep from 0: 60 increments back to 00
    @(negedge clk);
    s_ld = 1; s_inc = 0; s_dec = 0; s_lv = 8'h00;
    @(negedge clk);
    s_ld = 0; s_inc = 1;
    for (int k = 0; k < 60; k++) begin
      #1;
      check($sformatf("sweep%0d_carry", k), 32'(s_c), 32'(k == 59));
      @(posedge clk);
      #1;
      check($sformatf("sweep%0d_count", k), 32'(s_cnt), 32'(dec2bcd((k + 1) % 60)));
      @(negedge clk);
    end
    s_inc = 0;

    // asynchronous reset mid-count at 37, with a load pending
    s_ld = 1; s_lv = 8'h37;
    @(negedge clk);
    s_ld = 0;
    #1;
    check("pre_reset_count", 32'(s_cnt), 32'h37);
    @(posedge clk);
    #2;
    rst_ni = 1'b0;
    s_ld = 1; s_lv = 8'h45; s_inc = 1;
    #1;
    check("async_reset_count", 32'(s_cnt), 32'h00);
    check("async_reset_err", 32'(s_e), 32'h0);
    check("async_reset_carry", 32'(s_c), 32'h0);
    @(posedge clk);
    #1;
    check("reset_beats_load", 32'(s_cnt), 32'h00);
    @(negedge clk);
    s_ld = 0; s_inc = 0;
    rst_ni = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_count", k), 32'(s_cnt), 32'h00);
      check($sformatf("hold%0d_carry", k), 32'(s_c), 32'h0);
    end

    // cascade: 12 minutes past, seconds wrap steps minutes only
    @(negedge clk);
    s_ld = 1; s_lv = 8'h59; m_ld = 1; m_lv = 8'h12; h_ld = 1; h_lv = 8'h07;
    @(negedge clk);
    s_ld = 0; m_ld = 0; h_ld = 0; s_inc = 1;
    #1;
    check("casc1_sec_carry", 32'(s_c), 32'h1);
    check("casc1_min_carry", 32'(m_c), 32'h0);
    @(posedge clk);
    #1;
    check("casc1_time", {8'h0, h_cnt, m_cnt, s_cnt}, 32'h00071300);

    // cascade: 23:59:59 + 1 -> 00:00:00, all three carries together
    @(negedge clk);
    s_inc = 0;
    s_ld = 1; s_lv = 8'h59; m_ld = 1; m_lv = 8'h59; h_ld = 1; h_lv = 8'h23;
    @(negedge clk);
    s_ld = 0; m_ld = 0; h_ld = 0; s_inc = 1;
    #1;
    check("casc2_carries", {29'h0, h_c, m_c, s_c}, 32'h7);
    @(posedge clk);
    #1;
    check("casc2_time", {8'h0, h_cnt, m_cnt, s_cnt}, 32'h00000000);
    @(negedge clk);
    s_inc = 0;
    #1;
    check("casc2_carries_clear", {29'h0, h_c, m_c, s_c}, 32'h0);

    // hours range check: 24 is rejected by the MAX_COUNT=23 stage
    h_ld = 1; h_lv = 8'h24;
    @(posedge clk);
    #1;
    check("hr_load24_err", 32'(h_e), 32'h1);
    check("hr_load24_count", 32'(h_cnt), 32'h00);
    @(negedge clk);
    h_ld = 0;

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
